// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] NOP     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: instruction memory port, pipeline control inputs, IF/ID outputs.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic [XLEN-1:0] im_pc;
  logic [XLEN-1:0] im_instr;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_pc4;
  logic [XLEN-1:0] ifid_instr;
  logic            halted;
  logic            fetch_err;

  modport master (
    output im_pc, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, halted, fetch_err,
    input  im_instr, stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  im_pc, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, halted, fetch_err,
    output im_instr, stall, flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; clear wins over enable and only drops the valid bit.
module ifid_reg
  import if_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  input  ifid_t d,
  output logic  valid,
  output ifid_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '{pc: '0, pc4: '0, instr: NOP};
    end else if (clr) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC/FSM control feeding a single IF/ID register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_WORDS = 1024
) (
  input logic        clk,
  input logic        rst_n,
  if_fetch_if.master bus
);

  // One extra bit so a sequential wrap past 32'hFFFF_FFFC still reads as out of range.
  localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(IM_WORDS) << 2;

  fetch_state_t    state;
  logic [XLEN:0]   pc;
  logic            fetch_err_q;
  logic            halted_q;

  logic            redir_bad_c;
  logic            pc_bad_c;
  logic            squash_c;
  ifid_t           ifid_d;
  ifid_t           ifid_q;
  logic            ifid_valid_q;

  assign redir_bad_c = bus.redirect_valid && misaligned(bus.redirect_pc);
  assign pc_bad_c    = (pc >= PC_LIMIT) || misaligned(pc[XLEN-1:0]);
  assign squash_c    = (state != ST_RUN) || bus.flush || bus.redirect_valid || pc_bad_c;
  assign ifid_d      = '{pc: pc[XLEN-1:0], pc4: pc[XLEN-1:0] + PC_STEP, instr: bus.im_instr};

  // PC, state and sticky fault; redirect beats fault, fault beats flush, flush beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= {1'b0, RESET_PC};
      fetch_err_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          if (redir_bad_c) begin
            fetch_err_q <= 1'b1;
            halted_q    <= 1'b1;
            state       <= ST_HALT;
          end else if (bus.redirect_valid) begin
            pc <= {1'b0, bus.redirect_pc};
          end
        end
        ST_RUN: begin
          if (redir_bad_c || (!bus.redirect_valid && pc_bad_c)) begin
            fetch_err_q <= 1'b1;
            halted_q    <= 1'b1;
            state       <= ST_HALT;
          end else if (bus.redirect_valid) begin
            pc <= {1'b0, bus.redirect_pc};
          end else if (!bus.flush && !bus.stall) begin
            pc <= pc + (XLEN+1)'(PC_STEP);
          end
        end
        ST_HALT: begin
          if (redir_bad_c) begin
            fetch_err_q <= 1'b1;
          end else if (bus.redirect_valid) begin
            pc       <= {1'b0, bus.redirect_pc};
            halted_q <= 1'b0;
            state    <= ST_RUN;
          end
        end
        default: begin
          state    <= ST_BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!bus.stall),
    .clr   (squash_c),
    .d     (ifid_d),
    .valid (ifid_valid_q),
    .q     (ifid_q)
  );

  assign bus.im_pc      = pc[XLEN-1:0];
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_pc    = ifid_q.pc;
  assign bus.ifid_pc4   = ifid_q.pc4;
  assign bus.ifid_instr = ifid_q.instr;
  assign bus.halted     = halted_q;
  assign bus.fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a combinational instruction-memory model.
module tb_if_fetch;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .IM_WORDS (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: word at 0 is 32'h2001_0005, every other word is 32'hA500_0000 | addr.
  always_comb begin
    if (bus.im_pc == 32'h0) bus.im_instr = 32'h2001_0005;
    else                    bus.im_instr = 32'hA500_0000 | bus.im_pc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic s, input logic f, input logic rv, input logic [31:0] rp);
    bus.stall          = s;
    bus.flush          = f;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(bus.ifid_valid), 32'(v));
    chk({tag, "_pc"},    bus.ifid_pc,          pc);
    chk({tag, "_pc4"},   bus.ifid_pc4,         pc + 32'd4);
    chk({tag, "_instr"}, bus.ifid_instr,       instr);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_im_pc"},  bus.im_pc,                32'h0);
    chk({tag, "_valid"},  32'(bus.ifid_valid),      32'h0);
    chk({tag, "_pc"},     bus.ifid_pc,              32'h0);
    chk({tag, "_pc4"},    bus.ifid_pc4,             32'h0);
    chk({tag, "_instr"},  bus.ifid_instr,           32'h0);
    chk({tag, "_halted"}, 32'(bus.halted),          32'h0);
    chk({tag, "_err"},    32'(bus.fetch_err),       32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    chk_reset("rst");

    // Boot then sequential fetch
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("boot_im_pc", bus.im_pc, 32'h0);
    chk("boot_valid", 32'(bus.ifid_valid), 32'h0);
    tick();
    chk_ifid("f0", 1'b1, 32'h0, 32'h2001_0005);
    chk("f0_im_pc", bus.im_pc, 32'h4);
    tick();
    chk_ifid("f4", 1'b1, 32'h4, 32'hA500_0004);
    chk("f4_im_pc", bus.im_pc, 32'h8);
    tick();
    tick();
    chk("pre_stall_im_pc", bus.im_pc, 32'h10);
    chk_ifid("pre_stall", 1'b1, 32'hC, 32'hA500_000C);

    // Three-cycle stall at 0x10
    ctl(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_im_pc", bus.im_pc, 32'h10);
      chk_ifid("stall", 1'b1, 32'hC, 32'hA500_000C);
    end
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_ifid("resume10", 1'b1, 32'h10, 32'hA500_0010);
    tick();
    chk_ifid("resume14", 1'b1, 32'h14, 32'hA500_0014);
    chk("resume_im_pc", bus.im_pc, 32'h18);

    // Redirect beats stall
    ctl(1'b1, 1'b0, 1'b1, 32'h40);
    tick();
    chk("redir_im_pc", bus.im_pc, 32'h40);
    chk("redir_valid", 32'(bus.ifid_valid), 32'h0);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_ifid("redir40", 1'b1, 32'h40, 32'hA500_0040);

    // Flush overrides stall and holds pc
    ctl(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("flush_valid", 32'(bus.ifid_valid), 32'h0);
    chk("flush_im_pc", bus.im_pc, 32'h44);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_ifid("post_flush", 1'b1, 32'h44, 32'hA500_0044);

    // Run off the end of memory
    ctl(1'b0, 1'b0, 1'b1, 32'hFF8);
    tick();
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_ifid("ff8", 1'b1, 32'hFF8, 32'hA500_0FF8);
    tick();
    chk_ifid("ffc", 1'b1, 32'hFFC, 32'hA500_0FFC);
    chk("ffc_im_pc", bus.im_pc, 32'h1000);
    chk("ffc_halted", 32'(bus.halted), 32'h0);
    tick();
    chk("oor_halted", 32'(bus.halted), 32'h1);
    chk("oor_err", 32'(bus.fetch_err), 32'h1);
    chk("oor_valid", 32'(bus.ifid_valid), 32'h0);
    chk("oor_im_pc", bus.im_pc, 32'h1000);

    // HALT ignores stall and flush
    ctl(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    chk("halt_hold_halted", 32'(bus.halted), 32'h1);
    chk("halt_hold_im_pc", bus.im_pc, 32'h1000);
    chk("halt_hold_valid", 32'(bus.ifid_valid), 32'h0);

    // Aligned redirect leaves HALT, error stays sticky
    ctl(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("unhalt_halted", 32'(bus.halted), 32'h0);
    chk("unhalt_im_pc", bus.im_pc, 32'h0);
    chk("unhalt_err", 32'(bus.fetch_err), 32'h1);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_ifid("unhalt_f0", 1'b1, 32'h0, 32'h2001_0005);
    chk("unhalt_err2", 32'(bus.fetch_err), 32'h1);

    // Misaligned redirect faults without moving pc
    ctl(1'b0, 1'b0, 1'b1, 32'h22);
    tick();
    chk("mis_err", 32'(bus.fetch_err), 32'h1);
    chk("mis_halted", 32'(bus.halted), 32'h1);
    chk("mis_im_pc", bus.im_pc, 32'h4);
    chk("mis_valid", 32'(bus.ifid_valid), 32'h0);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset in HALT, checked before any further clock edge
    rst_n = 1'b0;
    #2;
    chk_reset("arst");

    // Redirect during BOOT
    ctl(1'b0, 1'b0, 1'b1, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("bootredir_im_pc", bus.im_pc, 32'h100);
    chk("bootredir_valid", 32'(bus.ifid_valid), 32'h0);
    chk("bootredir_halted", 32'(bus.halted), 32'h0);
    ctl(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_ifid("bootredir_f", 1'b1, 32'h100, 32'hA500_0100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
